// File: rtl/majority_bit_deframer_pkg.sv
// Shared frame definition for the majority-vote bit path: deframer states and frame geometry.
package majority_bit_deframer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } deframer_state_t;

    localparam logic DEFAULT_START_VAL = 1'b1;
    localparam int   DEFAULT_DATA_W    = 8;

    // Start + data + optional parity + stop, in voted bits.
    function automatic int frame_len(input int data_w, input bit parity_en);
        return 1 + data_w + (parity_en ? 1 : 0) + 1;
    endfunction

    localparam int DEFAULT_FRAME_LEN = frame_len(DEFAULT_DATA_W, 1'b0);

endpackage

// File: rtl/majority_bit_deframer_out_reg.sv
// One-entry valid/ready holding register for completed words, with sticky overflow on drop.
module majority_bit_deframer_out_reg
    import majority_bit_deframer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    logic accept;

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (load_valid) begin
            // A word arriving while the slot drains in the same cycle replaces it cleanly.
            if (!out_valid || out_ready) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/majority_bit_deframer.sv
// Frames voted bits (start, DATA_W data LSB first, optional even parity, stop) into words.
// state  | meaning
// IDLE   | waiting for a strobe carrying START_VAL
// DATA   | collecting data bits, idx = next bit position
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, emits word or error pulses
module majority_bit_deframer
    import majority_bit_deframer_pkg::*;
#(
    parameter int   DATA_W    = DEFAULT_DATA_W,
    parameter bit   PARITY_EN = 1'b0,
    parameter logic START_VAL = DEFAULT_START_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overflow,
    output logic              busy
);

    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    deframer_state_t   state, state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  idx;
    logic              parity_acc;
    logic              par_bad;
    logic              word_good;
    logic              stop_frame_bad;
    logic              stop_par_bad;

    always_comb begin
        state_next     = state;
        word_good      = 1'b0;
        stop_frame_bad = 1'b0;
        stop_par_bad   = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE:    if (bit_in == START_VAL) state_next = DATA;
                DATA:    if (idx == LAST_IDX) state_next = PARITY_EN ? PARITY : STOP;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next     = IDLE;
                    stop_frame_bad = (bit_in == START_VAL);
                    stop_par_bad   = par_bad;
                    word_good      = (bit_in != START_VAL) && !par_bad;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            idx        <= '0;
            parity_acc <= 1'b0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_next;
            frame_err  <= stop_frame_bad;
            parity_err <= stop_par_bad;
            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (bit_in == START_VAL) begin
                            idx        <= '0;
                            parity_acc <= 1'b0;
                            par_bad    <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg[idx] <= bit_in;
                        parity_acc     <= parity_acc ^ bit_in;
                        if (idx != LAST_IDX) idx <= idx + 1'b1;
                    end
                    PARITY:  par_bad <= (bit_in != parity_acc);
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    majority_bit_deframer_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(word_good),
        .load_data (shift_reg),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_majority_bit_deframer.sv
// Directed plus randomized frames against a frame-level model; dut_a has no parity, dut_b checks even parity.
module tb_majority_bit_deframer;
    import majority_bit_deframer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bv_a = 1'b0;
    logic       bv_b = 1'b0;
    logic       rdy = 1'b0;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b, perr_a, perr_b, ovf_a, ovf_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    majority_bit_deframer #(.DATA_W(8), .PARITY_EN(1'b0), .START_VAL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bv_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(rdy),
        .frame_err(ferr_a), .parity_err(perr_a), .overflow(ovf_a), .busy(busy_a));

    majority_bit_deframer #(.DATA_W(8), .PARITY_EN(1'b1), .START_VAL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bv_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(rdy),
        .frame_err(ferr_b), .parity_err(perr_b), .overflow(ovf_b), .busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one strobe at a falling edge, then idles with random line noise.
    task automatic strobe(input bit sel, input logic b, input int idle_max);
        @(negedge clk);
        bit_in = b;
        if (sel) bv_b = 1'b1; else bv_a = 1'b1;
        @(negedge clk);
        bv_a = 1'b0;
        bv_b = 1'b0;
        bit_in = 1'($urandom);
        if (idle_max > 0) repeat ($urandom_range(0, idle_max)) @(negedge clk);
    endtask

    // Returns at the falling edge right after the edge that consumed the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stop,
                              input bit drive_rdy, input logic rdy_val);
        strobe(sel, 1'b1, 2);
        for (int i = 0; i < 8; i++) strobe(sel, d[i], 2);
        if (sel) strobe(sel, par, 2);
        @(negedge clk);
        bit_in = stop;
        if (sel) bv_b = 1'b1; else bv_a = 1'b1;
        if (drive_rdy) rdy = rdy_val;
        @(negedge clk);
        bv_a = 1'b0;
        bv_b = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s, p, exp_good, exp_perr;

        repeat (2) @(negedge clk);
        chk("reset_valid", valid_a, 0);
        chk("reset_data", data_a, 0);
        chk("reset_ferr", ferr_a, 0);
        chk("reset_perr", perr_a, 0);
        chk("reset_ovf", ovf_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_valid_b", valid_b, 0);
        rst_n = 1'b1;

        repeat (3) strobe(1'b0, 1'b0, 1);
        repeat (3) strobe(1'b1, 1'b0, 1);
        chk("idle_busy_a", busy_a, 0);
        chk("idle_busy_b", busy_b, 0);

        rdy = 1'b1;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_valid", valid_a, 1);
        chk("a5_data", data_a, 8'hA5);
        chk("a5_ferr", ferr_a, 0);
        chk("a5_busy", busy_a, 0);
        @(negedge clk);
        chk("a5_accepted", valid_a, 0);

        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("badstop_ferr", ferr_a, 1);
        chk("badstop_valid", valid_a, 0);
        chk("badstop_busy", busy_a, 0);
        @(negedge clk);
        chk("badstop_ferr_pulse", ferr_a, 0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("3c_valid", valid_a, 1);
        chk("3c_data", data_a, 8'h3C);
        @(negedge clk);

        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par07_valid", valid_b, 1);
        chk("par07_data", data_b, 8'h07);
        chk("par07_perr", perr_b, 0);
        @(negedge clk);
        send_frame(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par07bad_perr", perr_b, 1);
        chk("par07bad_ferr", ferr_b, 0);
        chk("par07bad_valid", valid_b, 0);
        @(negedge clk);
        chk("par07bad_perr_pulse", perr_b, 0);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("both_perr", perr_b, 1);
        chk("both_ferr", ferr_b, 1);
        chk("both_valid", valid_b, 0);

        rdy = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf11_valid", valid_a, 1);
        chk("ovf11_ovf", ovf_a, 0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf22_data", data_a, 8'h11);
        chk("ovf22_valid", valid_a, 1);
        chk("ovf22_ovf", ovf_a, 1);
        repeat (4) @(negedge clk);
        chk("ovf_sticky", ovf_a, 1);
        rdy = 1'b1;
        @(negedge clk);
        chk("ovf_accept_valid", valid_a, 0);
        chk("ovf_after_accept", ovf_a, 1);

        pulse_reset();
        chk("ovf_cleared", ovf_a, 0);
        rdy = 1'b0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b55_data", data_a, 8'h55);
        send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2bAA_valid", valid_a, 1);
        chk("b2bAA_data", data_a, 8'hAA);
        chk("b2bAA_ovf", ovf_a, 0);
        @(negedge clk);
        chk("b2bAA_accepted", valid_a, 0);

        rdy = 1'b0;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 1);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'($urandom), 1);
        chk("midframe_busy", busy_a, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("f0_valid", valid_a, 1);
        chk("f0_data", data_a, 8'hF0);
        @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) == 0);
            exp_good = (s != 1'b1);
            send_frame(1'b0, d, 1'b0, s, 1'b0, 1'b0);
            chk("rnd_a_valid", valid_a, exp_good);
            if (exp_good) chk("rnd_a_data", data_a, d);
            chk("rnd_a_ferr", ferr_a, s);
            @(negedge clk);
            chk("rnd_a_drain", valid_a, 0);
        end

        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 2) == 0) ? ~even_par(d) : even_par(d);
            s = ($urandom_range(0, 3) == 0);
            exp_perr = (($countones(d) + p) % 2) != 0;
            exp_good = !s && !exp_perr;
            send_frame(1'b1, d, p, s, 1'b0, 1'b0);
            chk("rnd_b_valid", valid_b, exp_good);
            if (exp_good) chk("rnd_b_data", data_b, d);
            chk("rnd_b_perr", perr_b, exp_perr);
            chk("rnd_b_ferr", ferr_b, s);
            @(negedge clk);
            chk("rnd_b_drain", valid_b, 0);
        end
        chk("final_ovf_a", ovf_a, 0);
        chk("final_busy_b", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
